// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests one word, holds it for the decoder until
// accepted, then fetches the next; supports redirects and a terminal halt.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] inst_nxt, inst_pc_nxt, count_nxt;
  logic        accept;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Moore outputs decoded straight from the state register.
  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == VALID);
  assign halted     = (state == HALT);
  assign accept     = (state == VALID) && inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      inst        <= 32'h0;
      inst_pc     <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inst        <= inst_nxt;
      inst_pc     <= inst_pc_nxt;
      fetch_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    count_nxt   = fetch_count;
    case (state)
      FETCH: begin
        if (redirect) begin
          pc_nxt = word_align(redirect_pc);
        end else if (imem_ready) begin
          inst_nxt    = imem_rdata;
          inst_pc_nxt = pc;
          pc_nxt      = pc + 32'd4;
          state_nxt   = VALID;
        end
      end
      VALID: begin
        // An accepted word still counts even when a redirect lands with it.
        if (accept) count_nxt = fetch_count + 32'd1;
        if (redirect) begin
          pc_nxt    = word_align(redirect_pc);
          state_nxt = FETCH;
        end else if (accept) begin
          state_nxt = halt ? HALT : FETCH;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random traffic, all checked
// against a transaction-level model of the fetch unit.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Model: address to read next, the word held for the decoder (if any),
  // the accepted count, and whether fetching has stopped for good.
  logic [31:0] m_pc, m_inst, m_inst_pc, m_count;
  bit          m_have, m_halted;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_pc = RESET_PC; m_inst = '0; m_inst_pc = '0; m_count = '0;
    m_have = 0; m_halted = 0;
  endtask

  task automatic model_step(input logic rdy, input logic [31:0] rdat, input logic ird,
                            input logic hlt, input logic rd, input logic [31:0] rdpc);
    if (m_halted) return;
    if (m_have) begin
      if (ird) m_count = m_count + 1;
      if (rd) begin
        m_pc = rdpc & ~32'd3;
        m_have = 0;
      end else if (ird) begin
        m_have = 0;
        m_halted = hlt;
      end
    end else begin
      if (rd) m_pc = rdpc & ~32'd3;
      else if (rdy) begin
        m_inst = rdat; m_inst_pc = m_pc; m_pc = m_pc + 4; m_have = 1;
      end
    end
  endtask

  task automatic check_model;
    chk("imem_req", {31'b0, imem_req}, {31'b0, !m_halted && !m_have});
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_inst_pc);
    chk("fetch_count", fetch_count, m_count);
  endtask

  task automatic cycle(input logic rdy, input logic [31:0] rdat, input logic ird,
                       input logic hlt, input logic rd, input logic [31:0] rdpc);
    imem_ready = rdy; imem_rdata = rdat; inst_ready = ird;
    halt = hlt; redirect = rd; redirect_pc = rdpc;
    @(posedge clk);
    model_step(rdy, rdat, ird, hlt, rd, rdpc);
    #1 check_model;
  endtask

  // Reset is applied asynchronously, between clock edges.
  task automatic do_reset;
    imem_ready = 0; inst_ready = 0; halt = 0; redirect = 0;
    rst_n = 0;
    #1;
    model_reset;
    check_model;
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    #1 check_model;
  endtask

  initial begin
    #2;
    do_reset;
    chk("reset_addr", imem_addr, 32'h0000_3000);

    // Zero-wait memory, decoder always ready.
    for (int i = 0; i < 6; i++) cycle(1, 32'hA000_0000 + i, 1, 0, 0, 0);
    chk("seq_count", fetch_count, 32'd3);

    // Reset while an instruction is presented drops it uncounted.
    cycle(1, 32'h5555_0000, 0, 0, 0, 0);
    do_reset;
    chk("abandon_count", fetch_count, 32'd0);

    cycle(1, 32'hC0DE_0000, 1, 0, 0, 0);
    cycle(1, 32'h0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, $urandom, 1, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h0000_3004);
    end
    cycle(1, 32'hC0DE_0004, 0, 0, 0, 0);
    chk("wait_inst_pc", inst_pc, 32'h0000_3004);
    for (int i = 0; i < 4; i++) begin
      cycle(1, $urandom, 0, 0, 0, 0);
      chk("stall_inst", inst, 32'hC0DE_0004);
      chk("stall_count", fetch_count, 32'd1);
    end
    cycle(1, 32'h0, 1, 0, 0, 0);
    cycle(1, 32'hC0DE_0008, 0, 0, 0, 0);
    cycle(1, 32'h0, 1, 1, 0, 0);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, $urandom, 1, 1, 1, 32'h0000_5000);
      chk("halt_req", {31'b0, imem_req}, 32'd0);
    end
    do_reset;
    chk("halt_reset_addr", imem_addr, 32'h0000_3000);

    // Redirect racing read data; halt ignored when not accepted; wrap.
    cycle(1, 32'hDEAD_BEEF, 0, 0, 1, 32'h0000_4003);
    chk("redir_addr", imem_addr, 32'h0000_4000);
    chk("redir_valid", {31'b0, inst_valid}, 32'd0);
    cycle(0, 32'h0, 0, 1, 0, 0);
    cycle(1, 32'h1111_4000, 0, 1, 0, 0);
    cycle(1, 32'h0, 0, 1, 0, 0);
    chk("halt_no_accept", {31'b0, halted}, 32'd0);
    cycle(1, 32'h0, 1, 0, 1, 32'hFFFF_FFFC);
    chk("redir_accept_count", fetch_count, 32'd1);
    cycle(1, 32'h2222_FFFC, 1, 0, 0, 0);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    cycle(1, 32'h0, 1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (m_halted || $urandom_range(99) == 0) do_reset;
      else cycle($urandom_range(3) != 0, $urandom, $urandom_range(2) != 0,
                 $urandom_range(9) == 0, $urandom_range(11) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
